// File: rtl/rescueprime_pkg.sv
// Shared definitions for the Rescue-Prime sponge controller.
// Holds the FSM state encoding, default field parameters and the sponge
// geometry (state width 3, rate 2, capacity 1).
package rescueprime_pkg;

  localparam int unsigned DEF_N_BITS = 254;
  localparam logic [253:0] DEF_MODULUS =
    254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  localparam int unsigned RATE  = 2;
  localparam int unsigned WIDTH = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/rescueprime_mod_add.sv
// Combinational modular adder: sum_o = (a_i + b_i) mod MODULUS.
// Both operands are assumed already reduced (< MODULUS), so a single
// conditional subtraction suffices.
// Ports:
//   a_i, b_i : N_BITS operands
//   sum_o    : N_BITS reduced sum
module rescueprime_mod_add
  import rescueprime_pkg::*;
#(
  parameter int unsigned            N_BITS  = DEF_N_BITS,
  parameter logic [N_BITS-1:0]      MODULUS = N_BITS'(DEF_MODULUS)
) (
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  output logic [N_BITS-1:0] sum_o
);

  logic [N_BITS:0] raw;
  logic [N_BITS:0] mod_ext;

  assign mod_ext = {1'b0, MODULUS};
  assign raw     = {1'b0, a_i} + {1'b0, b_i};

  // One extra bit keeps the carry so the compare sees the true sum.
  always_comb begin
    if (raw >= mod_ext) begin
      sum_o = N_BITS'(raw - mod_ext);
    end else begin
      sum_o = N_BITS'(raw);
    end
  end

endmodule

// File: rtl/rescueprime_sponge_ctrl.sv
// Sponge-mode sequencer for one rescueprime_permute_3x core (width 3,
// rate 2, capacity 1). Absorbs field-element pairs into the rate lanes,
// launches the permutation per block and returns lane 1 as the digest.
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready              : message block handshake
//   in_elem_1, in_elem_2           : rate lane data
//   in_last, in_half               : final block / single-element final block
//   perm_start                     : one-cycle launch pulse to the core
//   perm_state_1..3                : sponge state presented to the core
//   perm_result_1..3, perm_done    : core results and completion pulse
//   out_valid/out_ready/out_digest : digest handshake
//   busy                           : high whenever not idle
// Optional build macro: RESCUE_SPONGE_DOMAIN_SEP_EN initialises the
// capacity lane to DOMAIN_TAG instead of zero.
module rescueprime_sponge_ctrl
  import rescueprime_pkg::*;
#(
  parameter int unsigned       N_BITS     = DEF_N_BITS,
  parameter logic [N_BITS-1:0] MODULUS    = N_BITS'(DEF_MODULUS),
  parameter logic [N_BITS-1:0] DOMAIN_TAG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_elem_1,
  input  logic [N_BITS-1:0] in_elem_2,
  input  logic              in_last,
  input  logic              in_half,
  output logic              perm_start,
  output logic [N_BITS-1:0] perm_state_1,
  output logic [N_BITS-1:0] perm_state_2,
  output logic [N_BITS-1:0] perm_state_3,
  input  logic [N_BITS-1:0] perm_result_1,
  input  logic [N_BITS-1:0] perm_result_2,
  input  logic [N_BITS-1:0] perm_result_3,
  input  logic              perm_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_digest,
  output logic              busy
);

`ifdef RESCUE_SPONGE_DOMAIN_SEP_EN
  localparam bit DOMAIN_SEP = 1'b1;
`else
  localparam bit DOMAIN_SEP = 1'b0;
`endif

  // Capacity-lane initial value, applied at reset and after each digest.
  localparam logic [N_BITS-1:0] S3_INIT = DOMAIN_SEP ? DOMAIN_TAG : '0;

  state_e state_q, state_d;

  logic [N_BITS-1:0] s1_q, s1_d;
  logic [N_BITS-1:0] s2_q, s2_d;
  logic [N_BITS-1:0] s3_q, s3_d;
  logic              last_q, last_d;

  logic in_ready_q, in_ready_d;
  logic perm_start_q, perm_start_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;

  logic [N_BITS-1:0] lane2_in;
  logic [N_BITS-1:0] add1_sum;
  logic [N_BITS-1:0] add2_sum;
  logic              accept;

  assign accept = in_valid && (state_q == S_IDLE);

  // A half block pads lane 2 with 1; a stray in_half on a non-final
  // block is treated as a full block.
  assign lane2_in = (in_half && in_last) ? N_BITS'(1) : in_elem_2;

  rescueprime_mod_add #(
    .N_BITS  (N_BITS),
    .MODULUS (MODULUS)
  ) u_add1 (
    .a_i   (s1_q),
    .b_i   (in_elem_1),
    .sum_o (add1_sum)
  );

  rescueprime_mod_add #(
    .N_BITS  (N_BITS),
    .MODULUS (MODULUS)
  ) u_add2 (
    .a_i   (s2_q),
    .b_i   (lane2_in),
    .sum_o (add2_sum)
  );

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= S3_INIT;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      perm_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      perm_start_q <= perm_start_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)    state_d = S_START;
      S_START:                state_d = S_WAIT;
      S_WAIT:  if (perm_done) state_d = last_q ? S_OUT : S_IDLE;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Sponge state update: absorb on accept, capture on done, reinit on digest.
  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    last_d = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          s1_d   = add1_sum;
          s2_d   = add2_sum;
          last_d = in_last;
        end
      end
      S_WAIT: begin
        if (perm_done) begin
          s1_d = perm_result_1;
          s2_d = perm_result_2;
          s3_d = perm_result_3;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          s1_d   = '0;
          s2_d   = '0;
          s3_d   = S3_INIT;
          last_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin
    in_ready_d   = 1'b0;
    perm_start_d = 1'b0;
    out_valid_d  = 1'b0;
    busy_d       = 1'b1;
    unique case (state_d)
      S_IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      S_START: perm_start_d = 1'b1;
      S_OUT:   out_valid_d  = 1'b1;
      default: ;
    endcase
  end

  assign in_ready     = in_ready_q;
  assign perm_start   = perm_start_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign perm_state_1 = s1_q;
  assign perm_state_2 = s2_q;
  assign perm_state_3 = s3_q;
  assign out_digest   = s1_q;

`ifndef SYNTHESIS
  // Flag the half-block protocol violation in simulation.
  always_ff @(posedge clk) begin
    if (rst_n && accept && in_half && !in_last) begin
      $warning("rescueprime_sponge_ctrl: in_half without in_last treated as full block");
    end
  end
`endif

endmodule

// File: tb/tb_rescueprime_sponge_ctrl.sv
// Directed bench for rescueprime_sponge_ctrl with N_BITS=8, MODULUS=251
// and a stub permutation returning (s2,s3,s1) four cycles after start.
module tb_rescueprime_sponge_ctrl;

  localparam int unsigned NB = 8;
  localparam logic [NB-1:0] MODV = 8'd251;
  localparam logic [NB-1:0] TAG  = 8'd7;
`ifdef RESCUE_SPONGE_DOMAIN_SEP_EN
  localparam logic [NB-1:0] S3I = TAG;
`else
  localparam logic [NB-1:0] S3I = 8'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_elem_1;
  logic [NB-1:0] in_elem_2;
  logic          in_last;
  logic          in_half;
  logic          perm_start;
  logic [NB-1:0] perm_state_1, perm_state_2, perm_state_3;
  logic [NB-1:0] perm_result_1 = '0;
  logic [NB-1:0] perm_result_2 = '0;
  logic [NB-1:0] perm_result_3 = '0;
  logic          perm_done = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_digest;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;

  always #5 clk = ~clk;

  rescueprime_sponge_ctrl #(
    .N_BITS     (NB),
    .MODULUS    (MODV),
    .DOMAIN_TAG (TAG)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_elem_1     (in_elem_1),
    .in_elem_2     (in_elem_2),
    .in_last       (in_last),
    .in_half       (in_half),
    .perm_start    (perm_start),
    .perm_state_1  (perm_state_1),
    .perm_state_2  (perm_state_2),
    .perm_state_3  (perm_state_3),
    .perm_result_1 (perm_result_1),
    .perm_result_2 (perm_result_2),
    .perm_result_3 (perm_result_3),
    .perm_done     (perm_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_digest    (out_digest),
    .busy          (busy)
  );

  // Stub core: rotate lanes, done pulse 4 cycles after start; ignores rst_n.
  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (perm_start) begin
      cnt           <= 4;
      perm_result_1 <= perm_state_2;
      perm_result_2 <= perm_state_3;
      perm_result_3 <= perm_state_1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) perm_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a block at a negedge, wait for acceptance, end one negedge later.
  task automatic send(input logic [NB-1:0] e1, input logic [NB-1:0] e2,
                      input logic last, input logic half, input logic hold);
    int n = 0;
    @(negedge clk);
    in_elem_1 = e1;
    in_elem_2 = e2;
    in_last   = last;
    in_half   = half;
    in_valid  = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!perm_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(perm_done), 32'd1);
  endtask

  task automatic take_digest();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_perm_start"}, 32'(perm_start), 32'd0);
    chk({tag, "_s1"}, 32'(perm_state_1), 32'd0);
    chk({tag, "_s2"}, 32'(perm_state_2), 32'd0);
    chk({tag, "_s3"}, 32'(perm_state_3), 32'(S3I));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_elem_1 = '0;
    in_elem_2 = '0;
    in_last   = 1'b0;
    in_half   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_digest", 32'(out_digest), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // Half block: lane 2 padded with 1, digest = old s2 = 1.
    send(8'd5, 8'd99, 1'b1, 1'b1, 1'b0);
    chk("half_start", 32'(perm_start), 32'd1);
    chk("half_s1", 32'(perm_state_1), 32'd5);
    chk("half_s2", 32'(perm_state_2), 32'd1);
    chk("half_s3", 32'(perm_state_3), 32'(S3I));
    chk("half_busy", 32'(busy), 32'd1);
    chk("half_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("half_pulse_width", 32'(perm_start), 32'd0);
    wait_done();
    chk("half_ov_at_done", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("half_ov", 32'(out_valid), 32'd1);
    chk("half_digest", 32'(out_digest), 32'd1);
    take_digest();
    chk_idle("half_after");

    // Two blocks with modular wrap: 100+160 = 260 -> 9.
    send(8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
    chk("wrap1_s1", 32'(perm_state_1), 32'd200);
    chk("wrap1_s2", 32'(perm_state_2), 32'd100);
    chk("wrap1_s3", 32'(perm_state_3), 32'(S3I));
    wait_done();
    @(negedge clk);
    chk("wrap1_idle", 32'(in_ready), 32'd1);
    chk("wrap1_no_ov", 32'(out_valid), 32'd0);
    chk("wrap1_res_s1", 32'(perm_state_1), 32'd100);
    chk("wrap1_res_s3", 32'(perm_state_3), 32'd200);
    send(8'd160, 8'd3, 1'b1, 1'b0, 1'b0);
    chk("wrap2_s1", 32'(perm_state_1), 32'd9);
    chk("wrap2_s2", 32'(perm_state_2), 32'(S3I + 8'd3));
    chk("wrap2_s3", 32'(perm_state_3), 32'd200);
    wait_done();
    @(negedge clk);
    chk("wrap2_ov", 32'(out_valid), 32'd1);
    chk("wrap2_digest", 32'(out_digest), 32'(S3I + 8'd3));
    take_digest();
    chk_idle("wrap_after");

    // Stall and backpressure: in_valid stays high with new data throughout.
    send(8'd1, 8'd2, 1'b1, 1'b0, 1'b1);
    in_elem_1 = 8'd50;
    in_elem_2 = 8'd60;
    chk("bp_s1", 32'(perm_state_1), 32'd1);
    chk("bp_s2", 32'(perm_state_2), 32'd2);
    chk("bp_s3", 32'(perm_state_3), 32'(S3I));
    begin
      int n = 0;
      while (!perm_done && n < 20) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_s1", 32'(perm_state_1), 32'd1);
        chk("stall_s2", 32'(perm_state_2), 32'd2);
        @(negedge clk);
        n++;
      end
      chk("bp_done_seen", 32'(perm_done), 32'd1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_digest", 32'(out_digest), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk_idle("bp_after");

    // Reset two cycles after perm_start, released before the stub's done.
    send(8'd10, 8'd20, 1'b1, 1'b0, 1'b0);
    chk("rw_start", 32'(perm_start), 32'd1);
    repeat (2) @(negedge clk);
    chk("rw_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rw_in_reset");
    chk("rw_digest", 32'(out_digest), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done();
    @(negedge clk);
    chk_idle("rw_late_done");
    @(negedge clk);
    chk_idle("rw_settled");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
